cpu_move_engine: RTL
====================

// Module: cpu_move_engine
// PURPOSE
//  Parametrised CPU opponent for the N x N tic-tac-toe game.
//  On a start pulse it latches the board and scans it one cell per clock.
//  It then returns the CPU move (row/col/index) according to the selected difficulty.
//  Sits between the game-control FSM (start/done handshake) and the board register/display path.
// PARAMETERS
//  BOARD_N    3        board side; CELLS = BOARD_N*BOARD_N; legal range 3..8
//  LFSR_SEED  16'hACE1 non-zero reset value of the internal 16-bit Galois LFSR (taps 16,14,13,11)
//  IDXW       $clog2(CELLS) width of move_idx (derived, not overridable)
//  POSW       $clog2(BOARD_N) width of move_row/move_col (derived)
// PORTS
//  clock      in   1          rising-edge clock
//  reset      in   1          synchronous, active-high reset
//  start      in   1          request a move; sampled only in IDLE
//  difficulty in   2          0=easy, 1=medium, 2=hard, 3=treated as hard
//  board      in   2*CELLS    cell i at [2i+1:2i]; 00=empty, 01=human, 10=CPU, 11=occupied(invalid)
//  busy       out  1          high from the cycle after start is accepted until done
//  done       out  1          one-cycle pulse: result outputs are valid
//  move_valid out  1          a legal move was found; held until next accepted start
//  no_move    out  1          board had no empty cell; held until next accepted start
//  move_idx   out  IDXW       chosen cell index (row*BOARD_N+col)
//  move_row   out  POSW       chosen row
//  move_col   out  POSW       chosen column
// BEHAVIOUR
//  Reset: state=IDLE, LFSR=LFSR_SEED, all outputs 0. Reset mid-scan aborts the scan; no done pulse.
//  LFSR advances every cycle, including IDLE, so the random stream depends on start timing.
//  FSM states: IDLE -> SCAN -> RESOLVE -> (RAND) -> DONE -> IDLE.
//  IDLE: on start=1, latch board and difficulty, clear move_valid/no_move, reset scan index to 0.
//    start while busy is ignored. Later changes on board/difficulty do not affect the running scan.
//  SCAN: runs CELLS cycles, idx 0..CELLS-1. For each empty cell i:
//    - empty_cnt++.
//    - Record first_empty, the lowest i.
//    - win_hit: placing CPU(10) at i completes its row, its column, or a diagonal it lies on.
//      Main diagonal applies when r==c; anti diagonal when r+c==N-1.
//    - blk_hit: the same check with human(01).
//    - Keep the lowest-index win_hit and the lowest-index blk_hit.
//    - Keep the lowest-index empty corner, corners in order 0, N-1, CELLS-N, CELLS-1.
//  RESOLVE, one cycle:
//    - empty_cnt==0: no_move=1 -> DONE.
//    - Hard: win > block > centre (BOARD_N odd and centre empty) > corner > first_empty.
//    - Medium: win, else go to RAND.
//    - Easy: always go to RAND.
//  RAND:
//    - r = LFSR[IDXW-1:0]; if r >= CELLS then r -= CELLS (one subtraction suffices).
//    - Walk idx = r, r+1, ... modulo CELLS, one cell per cycle.
//    - Take the first empty cell. This takes at most CELLS cycles.
//  DONE: done=1 for one cycle. Drive move_idx, move_row, move_col and move_valid; busy=0. Return to IDLE.
//    The next start may be accepted in the cycle after DONE.
//  Latency from start sampled to done high:
//    - deterministic path: exactly CELLS+2 cycles.
//    - RAND path: CELLS+3 .. 2*CELLS+2 cycles.
//  Row/column come from idx via counters kept alongside it. No divider is used.
//  Cells coded 11 count as occupied and never count toward any line.
// STRUCTURE
//  Shared package ttt_pkg: cell codes (CELL_EMPTY/HUMAN/CPU), difficulty codes (DIFF_EASY/MEDIUM/HARD), FSM state enum.
//  Sub-module cpu_line_check: combinational, parametrised by BOARD_N.
//    Inputs: latched board, candidate row/col, player code.
//    Output: 1 when a line completes through the candidate.
//    Instantiated twice, once for CPU and once for human.
//  Top level holds the FSM, scan counters, LFSR and result registers.
// TESTING
//  1. 3x3, hard, empty board, start -> done 11 cycles later; idx=4 (1,1); move_valid=1; busy high cycles 1..10.
//  2. 3x3, hard, CPU at 0,1 and human at 3,4 -> idx=2 (win beats block of 5).
//  3. 3x3, hard, human at 0,1 and CPU at 4 -> idx=2 (block).
//     Medium on the same board -> RAND path: the move is empty and done arrives within 12..20 cycles.
//  4. Full board, any difficulty -> done at +11, no_move=1, move_valid=0.
//     Then a second start with one empty cell (idx 7), easy -> idx=7.
//  5. Assert reset during SCAN -> next cycle: all outputs 0 and state IDLE, with no done.
//     A start during busy is ignored; board changes during the scan do not alter the result.
//  6. BOARD_N=4, hard, human on 0,5,10 and CPU on 1,2 -> idx=15 (anti/main diagonal block).
//     Easy over 200 starts -> every move lands on an empty cell.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared codes for the tic-tac-toe datapath: cell contents, difficulty levels,
// CPU move-engine FSM states and the random-source step function.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_HUMAN = 2'b01;
  localparam logic [1:0] CELL_CPU   = 2'b10;

  localparam logic [1:0] DIFF_EASY   = 2'd0;
  localparam logic [1:0] DIFF_MEDIUM = 2'd1;
  localparam logic [1:0] DIFF_HARD   = 2'd2;

  // Right-shifting Galois form of the x^16+x^14+x^13+x^11+1 polynomial
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESOLVE,
    ST_RAND,
    ST_DONE
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/cpu_line_check.sv
// Reports whether placing `player` on the (empty) candidate cell completes its
// row, its column, or a diagonal through it. Cells coded 11 never match.
module cpu_line_check
  import ttt_pkg::*;
#(
  parameter  int unsigned BOARD_N = 3,
  localparam int unsigned CELLS   = BOARD_N * BOARD_N,
  localparam int unsigned POSW    = $clog2(BOARD_N)
) (
  input  logic [2*CELLS-1:0] board,
  input  logic [POSW-1:0]    row,
  input  logic [POSW-1:0]    col,
  input  logic [1:0]         player,
  output logic               hit_c
);

  logic            row_ok;
  logic            col_ok;
  logic            dm_ok;
  logic            da_ok;
  logic            own;
  logic [POSW-1:0] rr;
  logic [POSW-1:0] cc;

  // Every other cell on a line through the candidate must already hold player
  always_comb begin
    row_ok = 1'b1;
    col_ok = 1'b1;
    dm_ok  = (row == col);
    da_ok  = ((int'(row) + int'(col)) == (int'(BOARD_N) - 1));
    own    = 1'b0;
    rr     = '0;
    cc     = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      own = (board[2*i +: 2] == player);
      rr  = POSW'(i / BOARD_N);
      cc  = POSW'(i % BOARD_N);
      if ((rr == row) && (cc != col) && !own) row_ok = 1'b0;
      if ((cc == col) && (rr != row) && !own) col_ok = 1'b0;
      if (((i / BOARD_N) == (i % BOARD_N)) && (rr != row) && !own) dm_ok = 1'b0;
      if (((i / BOARD_N) + (i % BOARD_N) == BOARD_N - 1) && (rr != row) && !own) da_ok = 1'b0;
    end
    hit_c = row_ok | col_ok | dm_ok | da_ok;
  end

endmodule

// File: rtl/cpu_move_engine.sv
// CPU opponent: latches the board on start, scans one cell per clock, then
// picks a move by difficulty (priority chain or LFSR-seeded walk).
module cpu_move_engine
  import ttt_pkg::*;
#(
  parameter  int unsigned BOARD_N   = 3,
  parameter  logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int unsigned CELLS     = BOARD_N * BOARD_N,
  localparam int unsigned IDXW      = $clog2(CELLS),
  localparam int unsigned POSW      = $clog2(BOARD_N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         difficulty,
  input  logic [2*CELLS-1:0] board,
  output logic               busy,
  output logic               done,
  output logic               move_valid,
  output logic               no_move,
  output logic [IDXW-1:0]    move_idx,
  output logic [POSW-1:0]    move_row,
  output logic [POSW-1:0]    move_col
);

  localparam int unsigned CNTW       = $clog2(CELLS + 1);
  localparam int unsigned CENTRE_IDX = (CELLS - 1) / 2;
  localparam int unsigned CENTRE_POS = BOARD_N / 2;
  localparam bit          HAS_CENTRE = (BOARD_N % 2) == 1;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
    logic [POSW-1:0] row;
    logic [POSW-1:0] col;
  } cand_t;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [2*CELLS-1:0] board_q, board_d;
  logic [1:0]         diff_q, diff_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [POSW-1:0]    row_q, row_d;
  logic [POSW-1:0]    col_q, col_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  cand_t              first_q, first_d, win_q, win_d, blk_q, blk_d;
  cand_t              corner_q, corner_d, res_q, res_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               move_valid_q, move_valid_d, no_move_q, no_move_d;
  logic [IDXW-1:0]    move_idx_q, move_idx_d;
  logic [POSW-1:0]    move_row_q, move_row_d, move_col_q, move_col_d;

  logic               win_hit_c, blk_hit_c, cell_empty_c, corner_c, centre_free_c;
  logic               last_idx_c, last_col_c;
  logic [IDXW-1:0]    nxt_idx_c, rand_raw_c, rand_idx_c;
  logic [POSW-1:0]    nxt_row_c, nxt_col_c, rand_row_c, rand_col_c;
  cand_t              cur_c, centre_c;

  cpu_line_check #(.BOARD_N(BOARD_N)) u_win (
    .board(board_q), .row(row_q), .col(col_q), .player(CELL_CPU), .hit_c(win_hit_c)
  );

  cpu_line_check #(.BOARD_N(BOARD_N)) u_blk (
    .board(board_q), .row(row_q), .col(col_q), .player(CELL_HUMAN), .hit_c(blk_hit_c)
  );

  assign cell_empty_c  = (board_q[{idx_q, 1'b0} +: 2] == CELL_EMPTY);
  assign corner_c      = (idx_q == '0) || (idx_q == IDXW'(BOARD_N - 1)) ||
                         (idx_q == IDXW'(CELLS - BOARD_N)) || (idx_q == IDXW'(CELLS - 1));
  assign centre_free_c = HAS_CENTRE && (board_q[2*CENTRE_IDX +: 2] == CELL_EMPTY);
  assign cur_c         = '{found: 1'b1, idx: idx_q, row: row_q, col: col_q};
  assign centre_c      = '{found: 1'b1, idx: IDXW'(CENTRE_IDX),
                           row: POSW'(CENTRE_POS), col: POSW'(CENTRE_POS)};

  // Row/column counters step alongside idx, wrapping at the board end
  assign last_idx_c = (idx_q == IDXW'(CELLS - 1));
  assign last_col_c = (col_q == POSW'(BOARD_N - 1));
  assign nxt_idx_c  = last_idx_c ? '0 : idx_q + IDXW'(1);
  assign nxt_col_c  = last_col_c ? '0 : col_q + POSW'(1);
  assign nxt_row_c  = last_idx_c ? '0 : (last_col_c ? row_q + POSW'(1) : row_q);

  // Random start cell folded into range with a single subtraction
  assign rand_raw_c = lfsr_q[IDXW-1:0];
  assign rand_idx_c = ({1'b0, rand_raw_c} >= (IDXW + 1)'(CELLS)) ?
                      rand_raw_c - IDXW'(CELLS) : rand_raw_c;

  always_comb begin
    rand_row_c = '0;
    rand_col_c = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (rand_idx_c == IDXW'(i)) begin
        rand_row_c = POSW'(i / BOARD_N);
        rand_col_c = POSW'(i % BOARD_N);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_step(lfsr_q);
    board_d      = board_q;
    diff_d       = diff_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    win_d        = win_q;
    blk_d        = blk_q;
    corner_d     = corner_q;
    res_d        = res_q;
    busy_d       = (state_q == ST_SCAN) || (state_q == ST_RESOLVE) || (state_q == ST_RAND);
    done_d       = 1'b0;
    move_valid_d = move_valid_q;
    no_move_d    = no_move_q;
    move_idx_d   = move_idx_q;
    move_row_d   = move_row_q;
    move_col_d   = move_col_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          board_d      = board;
          diff_d       = difficulty;
          move_valid_d = 1'b0;
          no_move_d    = 1'b0;
          idx_d        = '0;
          row_d        = '0;
          col_d        = '0;
          cnt_d        = '0;
          first_d      = '0;
          win_d        = '0;
          blk_d        = '0;
          corner_d     = '0;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cell_empty_c) begin
          cnt_d = cnt_q + CNTW'(1);
          if (!first_q.found)              first_d  = cur_c;
          if (win_hit_c && !win_q.found)   win_d    = cur_c;
          if (blk_hit_c && !blk_q.found)   blk_d    = cur_c;
          if (corner_c && !corner_q.found) corner_d = cur_c;
        end
        idx_d = nxt_idx_c;
        row_d = nxt_row_c;
        col_d = nxt_col_c;
        if (last_idx_c) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        state_d = ST_DONE;
        if (cnt_q == '0) begin
          res_d = '0;
        end else if (diff_q >= DIFF_HARD) begin
          if (win_q.found)         res_d = win_q;
          else if (blk_q.found)    res_d = blk_q;
          else if (centre_free_c)  res_d = centre_c;
          else if (corner_q.found) res_d = corner_q;
          else                     res_d = first_q;
        end else if ((diff_q == DIFF_EASY) || !win_q.found) begin
          idx_d   = rand_idx_c;
          row_d   = rand_row_c;
          col_d   = rand_col_c;
          state_d = ST_RAND;
        end else begin
          res_d = win_q;
        end
      end
      ST_RAND: begin
        // Terminates within CELLS cycles: at least one empty cell was counted
        if (cell_empty_c) begin
          res_d   = cur_c;
          state_d = ST_DONE;
        end else begin
          idx_d = nxt_idx_c;
          row_d = nxt_row_c;
          col_d = nxt_col_c;
        end
      end
      ST_DONE: begin
        done_d       = 1'b1;
        move_valid_d = res_q.found;
        no_move_d    = !res_q.found;
        move_idx_d   = res_q.idx;
        move_row_d   = res_q.row;
        move_col_d   = res_q.col;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_SEED;
      board_q      <= '0;
      diff_q       <= '0;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      cnt_q        <= '0;
      first_q      <= '0;
      win_q        <= '0;
      blk_q        <= '0;
      corner_q     <= '0;
      res_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      move_valid_q <= 1'b0;
      no_move_q    <= 1'b0;
      move_idx_q   <= '0;
      move_row_q   <= '0;
      move_col_q   <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      board_q      <= board_d;
      diff_q       <= diff_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      win_q        <= win_d;
      blk_q        <= blk_d;
      corner_q     <= corner_d;
      res_q        <= res_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      move_valid_q <= move_valid_d;
      no_move_q    <= no_move_d;
      move_idx_q   <= move_idx_d;
      move_row_q   <= move_row_d;
      move_col_q   <= move_col_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign move_valid = move_valid_q;
  assign no_move    = no_move_q;
  assign move_idx   = move_idx_q;
  assign move_row   = move_row_q;
  assign move_col   = move_col_q;

endmodule
